// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: FSM encoding, requester IDs and default widths.
package mem_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_DONE   = DONE;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU port, loader port and RAM-side signals around mem_arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = mem_pkg::DEF_DATA_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_ack;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_stall;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_stall,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_ack, ldr_rdata, ldr_stall,
        output ram_addr, ram_wdata, ram_we,
        input  ram_rdata
    );

    // Requester and RAM side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_stall,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_ack, ldr_rdata, ldr_stall,
        input  ram_addr, ram_wdata, ram_we,
        output ram_rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the requester that did not win last time wins.
module rr_pick2
    import mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       win_o,
    output logic       vld_o
);

    always_comb begin
        vld_o = |req_i;
        if (&req_i) begin
            win_o = ~last_i;
        end else begin
            win_o = req_i[1] ? REQ_LDR : REQ_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing one single-port synchronous RAM between the CPU and the loader port.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus,
    output logic           busy,
    output logic           last_grant
);

    localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              ldr_ack_q, ldr_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

    logic pick_win;
    logic pick_vld;

    rr_pick2 u_pick (
        .req_i  ({bus.ldr_req, bus.cpu_req}),
        .last_i (last_q),
        .win_o  (pick_win),
        .vld_o  (pick_vld)
    );

    // last_q doubles as the owner of the transaction in flight
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        ldr_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    last_d      = pick_win;
                    ram_addr_d  = (pick_win == REQ_LDR) ? bus.ldr_addr  : bus.cpu_addr;
                    ram_wdata_d = (pick_win == REQ_LDR) ? bus.ldr_wdata : bus.cpu_wdata;
                    ram_we_d    = (pick_win == REQ_LDR) ? bus.ldr_we    : bus.cpu_we;
                    cnt_d       = '0;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (ram_we_q || (cnt_q == CNT_W'(RD_LAT))) begin
                    if (!ram_we_q) begin
                        if (last_q == REQ_LDR) ldr_rdata_d = bus.ram_rdata;
                        else                   cpu_rdata_d = bus.ram_rdata;
                    end
                    cpu_ack_d = (last_q == REQ_CPU);
                    ldr_ack_d = (last_q == REQ_LDR);
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= REQ_LDR;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            cpu_ack_q   <= cpu_ack_d;
            ldr_ack_q   <= ldr_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.ldr_ack   = ldr_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ldr_rdata = ldr_rdata_q;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;
    assign bus.ldr_stall = bus.ldr_req & ~ldr_ack_q;
    assign busy          = (state_q != ST_IDLE);
    assign last_grant    = last_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3, each behind a RAM model.
module tb_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if3 ();

    logic busy1, lg1, busy3, lg3;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .bus        (if1.slave),
        .busy       (busy1),
        .last_grant (lg1)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .bus        (if3.slave),
        .busy       (busy3),
        .last_grant (lg3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: one-cycle and three-cycle read latency
    logic [DW-1:0] mem1 [0:511];
    logic [DW-1:0] mem3 [0:511];
    logic [DW-1:0] rd1;
    logic [DW-1:0] p3 [0:2];

    always @(posedge clk) begin
        if (if1.ram_we) mem1[if1.ram_addr] <= if1.ram_wdata;
        rd1 <= mem1[if1.ram_addr];
        if (if3.ram_we) mem3[if3.ram_addr] <= if3.ram_wdata;
        p3[0] <= mem3[if3.ram_addr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign if1.ram_rdata = rd1;
    assign if3.ram_rdata = p3[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One transaction on the RD_LAT=1 instance; lat counts negedges from request to visible ack
    task automatic run1(input logic port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output int lat, output int stalls);
        logic got;
        @(negedge clk);
        if (port) begin
            if1.ldr_req = 1'b1; if1.ldr_we = we; if1.ldr_addr = addr; if1.ldr_wdata = wd;
        end else begin
            if1.cpu_req = 1'b1; if1.cpu_we = we; if1.cpu_addr = addr; if1.cpu_wdata = wd;
        end
        lat = 0; stalls = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (port ? if1.ldr_ack : if1.cpu_ack) begin
                got = 1'b1;
                if (port) if1.ldr_req = 1'b0; else if1.cpu_req = 1'b0;
            end else if (port ? if1.ldr_stall : if1.cpu_stall) begin
                stalls++;
            end
        end
        if1.cpu_req = 1'b0;
        if1.ldr_req = 1'b0;
    endtask

    task automatic run3(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        output int lat, output int stalls);
        logic got;
        @(negedge clk);
        if3.cpu_req = 1'b1; if3.cpu_we = we; if3.cpu_addr = addr; if3.cpu_wdata = wd;
        lat = 0; stalls = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (if3.cpu_ack) begin
                got = 1'b1;
                if3.cpu_req = 1'b0;
            end else if (if3.cpu_stall) begin
                stalls++;
            end
        end
        if3.cpu_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, st, n, cpu_at, ldr_at, lg_a, lg_b, acks;
        logic [DW-1:0] who [0:5];
        int cyc [0:5];
        total = 0; bad = 0;
        rst = 1'b0;
        if1.cpu_req = 0; if1.cpu_we = 0; if1.cpu_addr = '0; if1.cpu_wdata = '0;
        if1.ldr_req = 0; if1.ldr_we = 0; if1.ldr_addr = '0; if1.ldr_wdata = '0;
        if3.cpu_req = 0; if3.cpu_we = 0; if3.cpu_addr = '0; if3.cpu_wdata = '0;
        if3.ldr_req = 0; if3.ldr_we = 0; if3.ldr_addr = '0; if3.ldr_wdata = '0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy1, 0);
        chk("rst_ram_we", if1.ram_we, 0);
        chk("rst_ram_addr", if1.ram_addr, 0);
        chk("rst_ram_wdata", if1.ram_wdata, 0);
        chk("rst_acks", {if1.cpu_ack, if1.ldr_ack}, 0);
        chk("rst_rdata", {if1.cpu_rdata, if1.ldr_rdata}, 0);
        chk("rst_last_grant", lg1, 1);
        @(negedge clk);
        rst = 1'b1;

        // CPU write 0x012 <- DEADBEEF, cycle by cycle
        @(negedge clk);
        if1.cpu_req = 1; if1.cpu_we = 1; if1.cpu_addr = 9'h012; if1.cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_ram_we", if1.ram_we, 1);
        chk("wr_ram_addr", if1.ram_addr, 9'h012);
        chk("wr_ram_wdata", if1.ram_wdata, 32'hDEADBEEF);
        chk("wr_last_grant", lg1, 0);
        chk("wr_busy", busy1, 1);
        chk("wr_ack_early", if1.cpu_ack, 0);
        chk("wr_stall", if1.cpu_stall, 1);
        @(negedge clk);
        chk("wr_ram_we_off", if1.ram_we, 0);
        chk("wr_cpu_ack", if1.cpu_ack, 1);
        chk("wr_ldr_ack", if1.ldr_ack, 0);
        chk("wr_stall_off", if1.cpu_stall, 0);
        if1.cpu_req = 0;
        @(negedge clk);
        chk("wr_ack_pulse", if1.cpu_ack, 0);
        chk("wr_idle", busy1, 0);
        chk("wr_mem", mem1[9'h012], 32'hDEADBEEF);

        // Loader read back, then loader write / CPU read
        run1(1'b1, 1'b0, 9'h012, '0, lat, st);
        chk("ldr_rd_lat", lat, 3);
        chk("ldr_rd_stalls", st, 2);
        chk("ldr_rdata", if1.ldr_rdata, 32'hDEADBEEF);
        chk("ldr_rd_cpu_hold", if1.cpu_rdata, 0);
        chk("ldr_rd_last", lg1, 1);
        run1(1'b1, 1'b1, 9'h034, 32'h12345678, lat, st);
        chk("ldr_wr_lat", lat, 2);
        run1(1'b0, 1'b0, 9'h034, '0, lat, st);
        chk("cpu_rd_lat", lat, 3);
        chk("cpu_rdata", if1.cpu_rdata, 32'h12345678);
        chk("cpu_rd_ldr_hold", if1.ldr_rdata, 32'hDEADBEEF);

        // Simultaneous requests straight after reset
        do_reset();
        chk("tie_last_rst", lg1, 1);
        @(negedge clk);
        if1.cpu_req = 1; if1.cpu_we = 1; if1.cpu_addr = 9'h040; if1.cpu_wdata = 32'h0A0A0A0A;
        if1.ldr_req = 1; if1.ldr_we = 1; if1.ldr_addr = 9'h041; if1.ldr_wdata = 32'h0B0B0B0B;
        cpu_at = -1; ldr_at = -1; lg_a = -1; lg_b = -1; acks = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) lg_a = int'(lg1);
            if (i == 4) lg_b = int'(lg1);
            if (if1.cpu_ack && if1.ldr_ack) acks++;
            if (if1.cpu_ack) begin cpu_at = i; if1.cpu_req = 0; end
            if (if1.ldr_ack) begin ldr_at = i; if1.ldr_req = 0; end
        end
        chk("tie_lg_first", lg_a, 0);
        chk("tie_lg_second", lg_b, 1);
        chk("tie_cpu_ack_at", cpu_at, 2);
        chk("tie_ldr_ack_at", ldr_at, 5);
        chk("tie_no_overlap", acks, 0);
        chk("tie_mem_cpu", mem1[9'h040], 32'h0A0A0A0A);
        chk("tie_mem_ldr", mem1[9'h041], 32'h0B0B0B0B);

        // Both ports requesting continuously: strict alternation, one write every 3 cycles
        @(negedge clk);
        if1.cpu_req = 1; if1.cpu_we = 1; if1.cpu_addr = 9'h050; if1.cpu_wdata = 32'h1;
        if1.ldr_req = 1; if1.ldr_we = 1; if1.ldr_addr = 9'h051; if1.ldr_wdata = 32'h2;
        n = 0;
        for (int i = 1; i <= 40 && n < 6; i++) begin
            @(negedge clk);
            if (if1.cpu_ack || if1.ldr_ack) begin
                who[n] = {31'd0, if1.ldr_ack};
                cyc[n] = i;
                n++;
                if (n == 6) begin if1.cpu_req = 0; if1.ldr_req = 0; end
            end
        end
        if1.cpu_req = 0; if1.ldr_req = 0;
        chk("rr_count", n, 6);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("rr_who%0d", k), who[k], k % 2);
            chk($sformatf("rr_cyc%0d", k), cyc[k], 2 + 3 * k);
        end

        // Reset pulled during a read's ACCESS cycle
        @(negedge clk);
        @(negedge clk);
        if1.cpu_req = 1; if1.cpu_we = 0; if1.cpu_addr = 9'h012;
        @(negedge clk);
        chk("abort_busy_before", busy1, 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", busy1, 0);
        chk("abort_ram_we", if1.ram_we, 0);
        chk("abort_acks", {if1.cpu_ack, if1.ldr_ack}, 0);
        chk("abort_rdata", if1.cpu_rdata, 0);
        @(negedge clk);
        if1.cpu_req = 0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b1;
            if (if1.cpu_ack || if1.ldr_ack) acks++;
        end
        chk("abort_no_ack", acks, 0);
        run1(1'b0, 1'b0, 9'h012, '0, lat, st);
        chk("reissue_lat", lat, 3);
        chk("reissue_rdata", if1.cpu_rdata, 32'hDEADBEEF);

        // RD_LAT=3 instance, top address
        run3(1'b1, 9'h1FF, 32'hCAFEF00D, lat, st);
        chk("l3_wr_lat", lat, 2);
        run3(1'b0, 9'h1FF, '0, lat, st);
        chk("l3_rd_lat", lat, 5);
        chk("l3_rd_stalls", st, 4);
        chk("l3_rdata", if3.cpu_rdata, 32'hCAFEF00D);
        @(negedge clk);
        chk("l3_ack_pulse", if3.cpu_ack, 0);
        chk("l3_idle", busy3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
